// File: rtl/alu_uart_pkg.sv
// Shared state encoding and default widths for the UART-to-ALU sequencer.
package alu_uart_pkg;

    localparam int unsigned NBIT_DATA_LEN = 8;
    localparam int unsigned NBIT_OP_LEN   = 6;

    typedef enum logic [2:0] {
        S_WAIT_A   = 3'd0,
        S_WAIT_B   = 3'd1,
        S_WAIT_OP  = 3'd2,
        S_ALU_WAIT = 3'd3,
        S_TX_START = 3'd4,
        S_TX_WAIT  = 3'd5
    } state_t;

endpackage

// File: rtl/alu_uart_sequencer_seq_timer.sv
// Saturating clear/enable up-counter with a terminal-count compare.
module seq_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] tc,
    output logic             hit_c
);

    logic [WIDTH-1:0] count;

    // Holds at all-ones rather than wrapping back into a false terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign hit_c = (count == tc);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B and opcode bytes from the UART receiver, drives the ALU,
// and hands the settled result to the UART transmitter.
module alu_uart_sequencer #(
    parameter int unsigned NBIT_DATA_LEN  = alu_uart_pkg::NBIT_DATA_LEN,
    parameter int unsigned NBIT_OP_LEN    = alu_uart_pkg::NBIT_OP_LEN,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned ALU_LATENCY    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_done_tick,
    input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
    input  logic [NBIT_DATA_LEN-1:0] alu_result_in,
    input  logic                     tx_done_tick,
    output logic [NBIT_DATA_LEN-1:0] alu_a,
    output logic [NBIT_DATA_LEN-1:0] alu_b,
    output logic [NBIT_OP_LEN-1:0]   alu_op,
    output logic                     tx_start,
    output logic [NBIT_DATA_LEN-1:0] tx_data_out,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     rx_overrun
);
    import alu_uart_pkg::*;

    localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > ALU_LATENCY) ? TIMEOUT_CYCLES : ALU_LATENCY;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);
    localparam logic [TW-1:0] TO_TC  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LAT_TC = TW'(ALU_LATENCY - 1);

    state_t        state;
    logic          tmr_clr_c;
    logic          tmr_en_c;
    logic          tmr_hit_c;
    logic [TW-1:0] tmr_tc_c;

    // One timer serves both the inter-byte timeout and the ALU settle wait.
    always_comb begin
        tmr_clr_c = 1'b0;
        tmr_en_c  = 1'b0;
        case (state)
            S_WAIT_A:            tmr_clr_c = 1'b1;
            S_WAIT_B, S_WAIT_OP: begin
                if (rx_done_tick) tmr_clr_c = 1'b1;
                else              tmr_en_c  = 1'b1;
            end
            S_ALU_WAIT:          tmr_en_c  = 1'b1;
            default:             tmr_clr_c = 1'b1;
        endcase
    end

    assign tmr_tc_c = (state == S_ALU_WAIT) ? LAT_TC : TO_TC;

    seq_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_c),
        .en    (tmr_en_c),
        .tc    (tmr_tc_c),
        .hit_c (tmr_hit_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_WAIT_A;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            tx_start    <= 1'b0;
            tx_data_out <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            rx_overrun  <= 1'b0;
            case (state)
                S_WAIT_A: begin
                    if (rx_done_tick) begin
                        alu_a <= rx_data_in;
                        busy  <= 1'b1;
                        state <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    // A byte arriving on the expiry cycle is still accepted.
                    if (rx_done_tick) begin
                        alu_b <= rx_data_in;
                        state <= S_WAIT_OP;
                    end else if (tmr_hit_c) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_WAIT_A;
                    end
                end
                S_WAIT_OP: begin
                    if (rx_done_tick) begin
                        alu_op <= rx_data_in[NBIT_OP_LEN-1:0];
                        state  <= S_ALU_WAIT;
                    end else if (tmr_hit_c) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_WAIT_A;
                    end
                end
                S_ALU_WAIT: begin
                    rx_overrun <= rx_done_tick;
                    if (tmr_hit_c) begin
                        tx_data_out <= alu_result_in;
                        tx_start    <= 1'b1;
                        state       <= S_TX_START;
                    end
                end
                S_TX_START: begin
                    rx_overrun <= rx_done_tick;
                    state      <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    rx_overrun <= rx_done_tick;
                    if (tx_done_tick) begin
                        busy  <= 1'b0;
                        state <= S_WAIT_A;
                    end
                end
                default: begin
                    tx_start    <= tx_start;
                    timeout_err <= timeout_err;
                    rx_overrun  <= rx_overrun;
                    state       <= S_WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with an adder ALU and a tx-byte scoreboard.
module tb_alu_uart_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_done_tick;
    logic [7:0] rx_data_in;
    logic [7:0] alu_result_in;
    logic       tx_done_tick;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data_out;
    logic       busy;
    logic       timeout_err;
    logic       rx_overrun;

    int n_total = 0;
    int n_pass  = 0;
    int tx_pulses = 0;
    int to_pulses = 0;
    int ov_pulses = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign alu_result_in = alu_a + alu_b;

    alu_uart_sequencer #(
        .NBIT_DATA_LEN  (8),
        .NBIT_OP_LEN    (6),
        .TIMEOUT_CYCLES (20),
        .ALU_LATENCY    (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_done_tick  (rx_done_tick),
        .rx_data_in    (rx_data_in),
        .alu_result_in (alu_result_in),
        .tx_done_tick  (tx_done_tick),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .tx_start      (tx_start),
        .tx_data_out   (tx_data_out),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .rx_overrun    (rx_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_done_tick = 1'b1;
        rx_data_in   = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rx_data_in   = 8'h00;
    endtask

    task automatic tx_done_pulse();
        @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    // Scoreboard side: every tx_start must carry the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            tx_pulses++;
            if (exp_q.size() == 0) check("sb_unexpected_tx", 32'd0, 32'd1);
            else                   check("sb_tx_data", 32'(tx_data_out), 32'(exp_q.pop_front()));
        end
        if (rst_n && timeout_err) to_pulses++;
        if (rst_n && rx_overrun)  ov_pulses++;
    end

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] exp, input bit ovr);
        send(a); idle(4);
        send(b); idle(4);
        exp_q.push_back(exp);
        send(op);
        check("frame_alu_a", 32'(alu_a), 32'(a));
        check("frame_alu_b", 32'(alu_b), 32'(b));
        check("frame_alu_op", 32'(alu_op), 32'(op[5:0]));
        check("tx_start_early", 32'(tx_start), 32'd0);
        idle(1);
        check("tx_start_latency", 32'(tx_start), 32'd1);
        check("tx_data_out", 32'(tx_data_out), 32'(exp));
        idle(1);
        check("tx_start_single", 32'(tx_start), 32'd0);
        check("busy_tx_wait", 32'(busy), 32'd1);
        if (ovr) begin
            send(8'hFF);
            check("rx_overrun_pulse", 32'(rx_overrun), 32'd1);
            check("overrun_alu_a", 32'(alu_a), 32'(a));
            idle(1);
            check("rx_overrun_clear", 32'(rx_overrun), 32'd0);
        end
        idle(25);
        check("tx_data_stable", 32'(tx_data_out), 32'(exp));
        check("busy_before_done", 32'(busy), 32'd1);
        tx_done_pulse();
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        rx_done_tick = 1'b0;
        rx_data_in   = 8'h00;
        tx_done_tick = 1'b0;
        idle(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_tx_data", 32'(tx_data_out), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Normal frame: 5 + 3
        run_frame(8'h05, 8'h03, 8'h20, 8'h08, 1'b0);

        // Stray tx_done_tick while idle
        tx_done_pulse();
        check("stray_done_busy", 32'(busy), 32'd0);
        check("stray_done_tx_start", 32'(tx_start), 32'd0);

        // Timeout after a lone A byte: pulse lands on the 20th edge after the A edge
        send(8'h05);
        check("to_busy_set", 32'(busy), 32'd1);
        idle(19);
        check("to_not_yet", 32'(timeout_err), 32'd0);
        check("to_busy_hold", 32'(busy), 32'd1);
        idle(1);
        check("to_pulse", 32'(timeout_err), 32'd1);
        check("to_busy_drop", 32'(busy), 32'd0);
        check("to_alu_a_kept", 32'(alu_a), 32'h05);
        idle(1);
        check("to_pulse_end", 32'(timeout_err), 32'd0);

        // Recovery frame, with an overrun byte during the transmitter wait
        run_frame(8'h01, 8'h02, 8'h20, 8'h03, 1'b1);

        // B byte sampled on the exact expiry edge wins over the timeout
        send(8'h07);
        idle(18);
        send(8'h09);
        check("coinc_no_timeout", 32'(timeout_err), 32'd0);
        check("coinc_alu_b", 32'(alu_b), 32'h09);
        check("coinc_busy", 32'(busy), 32'd1);
        idle(4);
        exp_q.push_back(8'h10);
        send(8'h20);
        idle(1);
        check("coinc_tx_start", 32'(tx_start), 32'd1);
        check("coinc_tx_data", 32'(tx_data_out), 32'h10);
        idle(6);
        tx_done_pulse();
        check("coinc_busy_done", 32'(busy), 32'd0);

        // Reset while waiting for the opcode
        send(8'h11); idle(2);
        send(8'h22); idle(2);
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_alu_a", 32'(alu_a), 32'd0);
        check("mid_rst_alu_b", 32'(alu_b), 32'd0);
        check("mid_rst_alu_op", 32'(alu_op), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data_out), 32'd0);
        check("mid_rst_pulses", 32'({tx_start, timeout_err, rx_overrun}), 32'd0);
        idle(2);

        // Frame after reset; opcode upper bits are dropped
        run_frame(8'h04, 8'h06, 8'hE0, 8'h0A, 1'b0);

        idle(3);
        check("tx_pulse_count", 32'(tx_pulses), 32'd4);
        check("timeout_pulse_count", 32'(to_pulses), 32'd1);
        check("overrun_pulse_count", 32'(ov_pulses), 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
Sequences the UART-to-ALU datapath. It collects three bytes from the UART receiver in order: operand A, operand B, then opcode. It drives them onto the ALU, waits a fixed ALU settle time, then captures the result and hands it to the UART transmitter with a start/done handshake. Inter-byte timeout and overrun detection keep a lost or extra byte from desynchronising the frame.

Parameters:
NBIT_DATA_LEN, 8, width of UART bytes, ALU operands and result
NBIT_OP_LEN, 6, ALU opcode width; low bits of the opcode byte
TIMEOUT_CYCLES, 50000, max clk cycles between bytes of one frame before abort (>=2)
ALU_LATENCY, 1, clk cycles from opcode applied to result valid (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
rx_done_tick  in  1  one-cycle pulse, rx_data_in valid
rx_data_in  in  NBIT_DATA_LEN  received byte
alu_result_in  in  NBIT_DATA_LEN  ALU combinational result
tx_done_tick  in  1  one-cycle pulse, transmitter finished byte
alu_a  out  NBIT_DATA_LEN  registered operand A
alu_b  out  NBIT_DATA_LEN  registered operand B
alu_op  out  NBIT_OP_LEN  registered opcode
tx_start  out  1  one-cycle pulse, start transmission
tx_data_out  out  NBIT_DATA_LEN  registered result byte, stable from tx_start until tx_done_tick
busy  out  1  high in any state other than S_WAIT_A
timeout_err  out  1  one-cycle pulse on frame abort
rx_overrun  out  1  one-cycle pulse when a byte is dropped

Behaviour:
- Reset (rst_n=0 at rising edge): state S_WAIT_A; all outputs 0; timer cleared. This overrides everything, including mid-frame and mid-transmission.
- States: S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_ALU_WAIT, S_TX_START, S_TX_WAIT.
- S_WAIT_A: on rx_done_tick: alu_a<=rx_data_in, timer<=0, go to S_WAIT_B. No timeout in this state.
- S_WAIT_B: on rx_done_tick: alu_b<=rx_data_in, timer<=0, go to S_WAIT_OP.
- S_WAIT_OP: on rx_done_tick: alu_op<=rx_data_in[NBIT_OP_LEN-1:0], timer<=0, go to S_ALU_WAIT. Upper opcode bits are ignored.
- Timeout, in S_WAIT_B and S_WAIT_OP only:
  - Timer increments each cycle without rx_done_tick.
  - When timer==TIMEOUT_CYCLES-1 and no rx_done_tick: timeout_err=1 for one cycle, go to S_WAIT_A.
  - alu_a, alu_b and alu_op keep their values.
  - If rx_done_tick coincides with expiry, the byte wins: it is accepted and the timer cleared.
- S_ALU_WAIT: stays ALU_LATENCY cycles, counted on the same timer. In the last cycle: tx_data_out<=alu_result_in, go to S_TX_START.
- S_TX_START: tx_start=1 for exactly this one cycle, go to S_TX_WAIT.
  - tx_start is a registered Moore output.
  - With ALU_LATENCY=1, tx_start is high in cycle n+2, where edge n accepts the opcode.
- S_TX_WAIT: on tx_done_tick go to S_WAIT_A. No timeout here; the wait for the transmitter is unbounded.
- rx_done_tick in S_ALU_WAIT, S_TX_START or S_TX_WAIT: byte dropped, rx_overrun=1 for one cycle, state unaffected.
- tx_done_tick outside S_TX_WAIT: ignored.
- Timer width: clog2(max(TIMEOUT_CYCLES, ALU_LATENCY)+1). It saturates and never wraps.
- Unreachable state encodings: go to S_WAIT_A, all outputs held.

Decomposition:
- Package alu_uart_pkg holds:
  - state localparams S_WAIT_A..S_TX_WAIT (3-bit encoding);
  - default width constants NBIT_DATA_LEN=8 and NBIT_OP_LEN=6.
- One sub-module, seq_timer: a clear/enable up-counter with a terminal-count compare, parameterised width. It is used for both the timeout and the ALU settle wait.
- The FSM and output registers stay in alu_uart_sequencer.

Test Plan:
- Setup: TIMEOUT_CYCLES=20, ALU_LATENCY=1, ALU model = add.
- Normal frame: bytes 0x05, 0x03, 0x20 spaced 5 cycles apart -> alu_a=0x05, alu_b=0x03, alu_op=0x20. tx_start pulses once, 2 cycles after the opcode tick, with tx_data_out=0x08. tx_done_tick 30 cycles later -> busy=0, state S_WAIT_A.
- Timeout: byte 0x05, then nothing -> timeout_err pulses exactly 20 cycles after the A tick, busy drops. Next bytes 0x01, 0x02, 0x20 -> tx_data_out=0x03.
- Coincident expiry: B byte arrives exactly on the expiry cycle -> no timeout_err, alu_b updated, frame completes.
- Overrun: rx_done_tick with 0xFF during S_TX_WAIT -> rx_overrun pulses once, alu_a unchanged. A stray tx_done_tick in S_WAIT_A -> no effect.
- Reset mid-frame: rst_n=0 for 1 cycle in S_WAIT_OP -> all outputs 0, busy=0. A following full frame works normally.
- Upper opcode bits: opcode byte 0xE0 -> alu_op=0x20.
